// File: rtl/div_n.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per clock.
// Latency WIDTH+2 edges to done (2 for divide-by-zero); init_in ignored while busy, never queued.
module div_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Rem,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, zero;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;
  logic             sub_ok;
  logic             b_is_zero;

  always_comb begin
    b_is_zero = (B == '0);
    a_abs     = (signed_in && A[WIDTH-1]) ? -A : A;
    b_abs     = (signed_in && B[WIDTH-1]) ? -B : B;
    // Partial remainder can exceed WIDTH bits for one step, so work one bit wider.
    rem_sh    = {rem, quo[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs};
    sub_ok    = (rem_sh >= {1'b0, dvs});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (init_in) state_nxt = b_is_zero ? FIX : CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      zero     <= 1'b0;
      Result   <= '0;
      Rem      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init_in) begin
            busy <= 1'b1;
            zero <= b_is_zero;
            dvs  <= b_abs;
            cnt  <= '0;
            if (b_is_zero) begin
              // Preload the divide-by-zero answer so FIX treats it like any result.
              quo   <= '1;
              rem   <= A;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              quo   <= a_abs;
              rem   <= '0;
              q_neg <= signed_in & (A[WIDTH-1] ^ B[WIDTH-1]);
              r_neg <= signed_in & A[WIDTH-1];
            end
          end
        end
        CALC: begin
          quo <= {quo[WIDTH-2:0], sub_ok};
          rem <= sub_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          Result   <= q_neg ? -quo : quo;
          Rem      <= r_neg ? -rem : rem;
          div_zero <= zero;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
